scfifo_s_showahead: RTL and testbench
=====================================

# scfifo_s_showahead

Single-clock, show-ahead (first-word-fall-through) FIFO for on-chip buffering inside one clock domain. It accepts one word per cycle and delivers one word per cycle with no bubbles, and the head word is always presented on `q` while `empty` is low. It generalises the single-address-width MLAB FIFO to depths up to 1024 words, using MLAB or M20K storage. Used wherever a producer and consumer share a clock but need decoupling with registered almost-full and almost-empty flags.

## Interface
- `LOG_DEPTH`, 5: storage address width; valid range 3..10.
- `WIDTH`, 32: data width.
- `NUM_WORDS`, 2**LOG_DEPTH: capacity limit, 1..2**LOG_DEPTH.
- `ALMOST_FULL_VALUE`, 28: `almost_full` threshold, 1..NUM_WORDS.
- `ALMOST_EMPTY_VALUE`, 2: `almost_empty` threshold, 1..NUM_WORDS.
- `FAMILY`, "S10": "Agilex", "S10" or "Other"; passed to storage.
- Out-of-range parameters raise `$error` at elaboration.

Ports:
- `clock` in 1: sole clock.
- `aclr_n` in 1: reset, **asynchronous, active-low**.
- `wrreq` in 1: push request.
- `data` in WIDTH: push data.
- `rdreq` in 1: pop/acknowledge of the word on `q`.
- `q` out WIDTH: head word, valid while `empty`=0.
- `empty` out 1: no word presented.
- `full` out 1: occupancy equals NUM_WORDS.
- `almost_empty` out 1: usedw < ALMOST_EMPTY_VALUE.
- `almost_full` out 1: usedw >= ALMOST_FULL_VALUE.
- `usedw` out LOG_DEPTH+1: occupancy, counting memory, prefetch and output stages.
- `overflow` out 1: sticky error flag; see Configuration.
- `underflow` out 1: sticky error flag; see Configuration.

## Operation
- **Push accept:** push accepted = `wrreq & ~full`. Pop accepted = `rdreq & ~empty`. Rejected requests change no state.
- **Write path:** write pointer and read pointer are LOG_DEPTH bits and wrap modulo 2**LOG_DEPTH. Storage has one registered read cycle.
- **Output pipeline:** memory → prefetch register (`pf_valid`) → output register `q` (`q_valid`). `empty` = ~`q_valid`.
- **Refill on pop:** on a pop, `q` loads from prefetch if `pf_valid`, otherwise becomes invalid. The prefetch stage refills whenever memory holds unread words and the stage is (or is becoming) free.
- **Occupancy:** `usedw` = usedw + push − pop, exact, never saturating. `full`, `almost_full` and `almost_empty` are registered and computed from next-usedw, so they are coherent with `usedw` on the same edge.
- **Simultaneous push/pop at full:** push is rejected (`full` is registered), pop proceeds, and `usedw` decrements.
- **Simultaneous push/pop at empty:** pop is rejected and push proceeds.
- **Reset:** assertion of `aclr_n`=0 immediately clears pointers, `usedw`=0, `q`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0. Contents are discarded mid-operation. Deassertion must be synchronous to `clock`; the integrator provides the synchroniser.

## Timing
- **Write to visible:** a push accepted at edge k updates `usedw` and flags after edge k. When the FIFO was empty, `q` is valid and `empty`=0 after edge k+2.
- **Read:** a pop at edge k presents the next word after edge k (zero-latency advance) whenever that word was accepted at or before edge k−2.
- **Throughput:** sustained simultaneous push/pop gives 1 word/cycle with no bubbles once non-empty.
- `full` asserts after the edge that accepts the NUM_WORDS-th word.

## Configuration
- **`SCFIFO_S_ERR_FLAGS_EN` defined:**
  - `overflow` sets on `wrreq & full`.
  - `underflow` sets on `rdreq & empty`.
  - Both are sticky until reset.
  - The bench asserts via SVA that `usedw` never exceeds NUM_WORDS.
- **`SCFIFO_S_ERR_FLAGS_EN` undefined:** `overflow` and `underflow` are tied to 0, the logic is not built, and there are no assertions. Request gating is unaffected either way.

## Structure
- **Package `scfifo_s_pkg`:**
  - function `clog2_words`
  - localparam for storage selection (MLAB when LOG_DEPTH ≤ 5, M20K otherwise)
  - parameter-range checking helper
- **Sub-module `generic_ram_sc`:** simple dual-port, one write port, registered read address, FAMILY- and size-driven storage attribute.
- All pointer, count and flag logic stays in the top.

## Test plan
- **Reset defaults:** reset, then idle 10 cycles → `empty`=1, `almost_empty`=1, `usedw`=0, `q`=0, `full`=0, `almost_full`=0.
- **First-word fall-through:** push 0xA5 once into an empty FIFO (LOG_DEPTH=5) → `usedw`=1 next cycle, `q`=0xA5 with `empty`=0 two cycles later; pop → `empty`=1, `usedw`=0.
- **Fill and overflow reject:** push 32 words 0..31 → `almost_full` after word 28, `full` after word 32. A 33rd push is rejected and `usedw` stays 32; with `SCFIFO_S_ERR_FLAGS_EN`, `overflow`=1. Then drain, checking order 0..31.
- **Streaming:** push and pop every cycle for 1000 cycles with random data → zero bubbles after fill, output order matches input, `usedw` constant.
- **Depth and wrap:** LOG_DEPTH=10, NUM_WORDS=1000, random push/pop at 50% each for 20000 cycles → scoreboard matches, pointers wrap many times, `usedw` matches the model every cycle.
- **Reset mid-operation:** with 17 words stored, pulse `aclr_n` low for one cycle mid-clock → all outputs at reset values immediately; a subsequent push of 0x1 reads back 0x1.

Source files
------------

// File: rtl/scfifo_s_pkg.sv
// Shared helpers for the show-ahead single-clock FIFO: sizing, storage selection
// and parameter range checking.
package scfifo_s_pkg;

   typedef enum logic {STORE_MLAB, STORE_M20K} store_e;

   // Address widths at or below this fit comfortably in MLAB; deeper goes to M20K.
   localparam int MLAB_MAX_LOG_DEPTH = 5;

   function automatic int clog2_words(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic store_e store_sel(input int log_depth);
      return (log_depth <= MLAB_MAX_LOG_DEPTH) ? STORE_MLAB : STORE_M20K;
   endfunction

   function automatic bit params_ok(input int log_depth, input int width, input int num_words,
                                    input int afv, input int aev, input string family);
      bit ok;
      ok = (log_depth >= 3) && (log_depth <= 10) && (width >= 1);
      ok = ok && (num_words >= 1) && (num_words <= (1 << log_depth));
      ok = ok && (afv >= 1) && (afv <= num_words) && (aev >= 1) && (aev <= num_words);
      ok = ok && ((family == "Agilex") || (family == "S10") || (family == "Other"));
      return ok;
   endfunction

endpackage

// File: rtl/generic_ram_sc.sv
// Simple dual-port RAM, one write port, read port with registered address.
// Storage style follows FAMILY and depth.
module generic_ram_sc
   import scfifo_s_pkg::*;
#(
   parameter int    AW     = 5,
   parameter int    DW     = 32,
   parameter string FAMILY = "S10"
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          re,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   localparam store_e STYLE = store_sel(AW);

   logic [AW-1:0] rd_addr_r;

   always_ff @(posedge clock)
      if (re) rd_addr_r <= rd_addr;

   if (FAMILY == "Other") begin : g_plain
      logic [DW-1:0] mem [2**AW];
      always_ff @(posedge clock)
         if (we) mem[wr_addr] <= wr_data;
      assign rd_data = mem[rd_addr_r];
   end else if (STYLE == STORE_MLAB) begin : g_mlab
      (* ramstyle = "MLAB, no_rw_check" *) logic [DW-1:0] mem [2**AW];
      always_ff @(posedge clock)
         if (we) mem[wr_addr] <= wr_data;
      assign rd_data = mem[rd_addr_r];
   end else begin : g_m20k
      (* ramstyle = "M20K, no_rw_check" *) logic [DW-1:0] mem [2**AW];
      always_ff @(posedge clock)
         if (we) mem[wr_addr] <= wr_data;
      assign rd_data = mem[rd_addr_r];
   end

endmodule

// File: rtl/scfifo_s_showahead.sv
// Single-clock show-ahead FIFO: memory -> prefetch -> output register.
// Optional sticky overflow/underflow flags under SCFIFO_S_ERR_FLAGS_EN.
module scfifo_s_showahead
   import scfifo_s_pkg::*;
#(
   parameter int    LOG_DEPTH          = 5,
   parameter int    WIDTH              = 32,
   parameter int    NUM_WORDS          = 2**LOG_DEPTH,
   parameter int    ALMOST_FULL_VALUE  = 28,
   parameter int    ALMOST_EMPTY_VALUE = 2,
   parameter string FAMILY             = "S10"
) (
   input  logic             clock,
   input  logic             aclr_n,
   input  logic             wrreq,
   input  logic [WIDTH-1:0] data,
   input  logic             rdreq,
   output logic [WIDTH-1:0] q,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [LOG_DEPTH:0] usedw,
   output logic             overflow,
   output logic             underflow
);

   localparam int CW = LOG_DEPTH + 1;
   localparam logic [CW-1:0] NW  = CW'(NUM_WORDS);
   localparam logic [CW-1:0] AFV = CW'(ALMOST_FULL_VALUE);
   localparam logic [CW-1:0] AEV = CW'(ALMOST_EMPTY_VALUE);

   if (!params_ok(LOG_DEPTH, WIDTH, NUM_WORDS, ALMOST_FULL_VALUE, ALMOST_EMPTY_VALUE, FAMILY))
   begin : g_param_err
      $error("scfifo_s_showahead: parameter out of range");
   end

   logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]        mem_cnt, usedw_nxt;
   logic                 pf_valid, q_valid;
   logic                 push, pop, pf_to_q, rd_issue;
   logic [WIDTH-1:0]     ram_q;

   assign empty     = ~q_valid;
   assign push      = wrreq & ~full;
   assign pop       = rdreq & q_valid;
   assign pf_to_q   = pf_valid & (~q_valid | pop);
   // Prefetch refills when memory has unread words and the stage is free or draining.
   assign rd_issue  = (mem_cnt != '0) & (~pf_valid | pf_to_q);
   assign usedw_nxt = usedw + CW'(push) - CW'(pop);

   generic_ram_sc #(.AW(LOG_DEPTH), .DW(WIDTH), .FAMILY(FAMILY)) u_ram (
      .clock   (clock),
      .we      (push),
      .wr_addr (wr_ptr),
      .wr_data (data),
      .re      (rd_issue),
      .rd_addr (rd_ptr),
      .rd_data (ram_q)
   );

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         mem_cnt      <= '0;
         pf_valid     <= 1'b0;
         q_valid      <= 1'b0;
         q            <= '0;
         usedw        <= '0;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         if (push)     wr_ptr <= wr_ptr + 1'b1;
         if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
         mem_cnt <= mem_cnt + CW'(push) - CW'(rd_issue);

         if (rd_issue)     pf_valid <= 1'b1;
         else if (pf_to_q) pf_valid <= 1'b0;

         if (pf_to_q) begin
            q       <= ram_q;
            q_valid <= 1'b1;
         end else if (pop) begin
            q_valid <= 1'b0;
         end

         // Flags come from next-usedw so they line up with usedw on the same edge.
         usedw        <= usedw_nxt;
         full         <= (usedw_nxt == NW);
         almost_full  <= (usedw_nxt >= AFV);
         almost_empty <= (usedw_nxt < AEV);
      end
   end

`ifdef SCFIFO_S_ERR_FLAGS_EN
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wrreq & full)  overflow  <= 1'b1;
         if (rdreq & empty) underflow <= 1'b1;
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_scfifo_s_showahead.sv
// Directed bench for scfifo_s_showahead: vector table plus fill, streaming,
// reset and deep random sequences on a 32-deep and a 1000-word instance.
module tb_scfifo_s_showahead;

   logic clock = 1'b0;
   logic aclr_n = 1'b0;
   always #5 clock = ~clock;

   logic        a_wrreq = 0, a_rdreq = 0;
   logic [31:0] a_data = '0, a_q;
   logic        a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
   logic [5:0]  a_usedw;

   logic        b_wrreq = 0, b_rdreq = 0;
   logic [31:0] b_data = '0, b_q;
   logic        b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
   logic [10:0] b_usedw;

   scfifo_s_showahead u_a (
      .clock(clock), .aclr_n(aclr_n), .wrreq(a_wrreq), .data(a_data), .rdreq(a_rdreq),
      .q(a_q), .empty(a_empty), .full(a_full), .almost_empty(a_ae), .almost_full(a_af),
      .usedw(a_usedw), .overflow(a_ovf), .underflow(a_unf));

   scfifo_s_showahead #(.LOG_DEPTH(10), .NUM_WORDS(1000)) u_b (
      .clock(clock), .aclr_n(aclr_n), .wrreq(b_wrreq), .data(b_data), .rdreq(b_rdreq),
      .q(b_q), .empty(b_empty), .full(b_full), .almost_empty(b_ae), .almost_full(b_af),
      .usedw(b_usedw), .overflow(b_ovf), .underflow(b_unf));

`ifdef SCFIFO_S_ERR_FLAGS_EN
   a_usedw_bound: assert property (@(posedge clock) disable iff (!aclr_n) a_usedw <= 6'd32);
   b_usedw_bound: assert property (@(posedge clock) disable iff (!aclr_n) b_usedw <= 11'd1000);
`endif

   int errs = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        wr, rd;
      logic [31:0] d;
      logic        e_empty;
      logic [31:0] e_q;
      logic [5:0]  e_usedw;
      logic        e_full, e_af, e_ae;
   } vec_t;

   vec_t tbl [12];
   logic [31:0] mq [$];
   logic [31:0] bq [$];

   initial begin
      // Inputs applied for one edge; expected outputs sampled at the following negedge.
      tbl[0]  = '{1'b1, 1'b0, 32'hA5, 1'b1, 32'h0,  6'd1, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  6'd1, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'hA5, 6'd1, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 32'h11, 1'b0, 32'hA5, 6'd2, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 32'h22, 1'b1, 32'h0,  6'd2, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h11, 6'd2, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 32'h0,  1'b0, 32'h22, 6'd1, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 32'h33, 1'b1, 32'h0,  6'd1, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  6'd1, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h33, 6'd1, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 32'h0,  1'b1, 32'h0,  6'd0, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 1'b1, 32'h0,  1'b1, 32'h0,  6'd0, 1'b0, 1'b0, 1'b1};

      // Reset defaults
      repeat (2) @(negedge clock);
      aclr_n = 1'b1;
      repeat (10) @(negedge clock);
      chk("rst_empty", a_empty, 1);
      chk("rst_ae", a_ae, 1);
      chk("rst_usedw", a_usedw, 0);
      chk("rst_q", a_q, 0);
      chk("rst_full", a_full, 0);
      chk("rst_af", a_af, 0);

      // Vector table: fall-through latency, pop refill, rejected pops
      for (int i = 0; i < 12; i++) begin
         a_wrreq = tbl[i].wr; a_rdreq = tbl[i].rd; a_data = tbl[i].d;
         @(negedge clock);
         chk($sformatf("vec%0d_empty", i), a_empty, tbl[i].e_empty);
         chk($sformatf("vec%0d_usedw", i), a_usedw, tbl[i].e_usedw);
         chk($sformatf("vec%0d_full", i), a_full, tbl[i].e_full);
         chk($sformatf("vec%0d_af", i), a_af, tbl[i].e_af);
         chk($sformatf("vec%0d_ae", i), a_ae, tbl[i].e_ae);
         if (!tbl[i].e_empty) chk($sformatf("vec%0d_q", i), a_q, tbl[i].e_q);
      end
      a_wrreq = 0; a_rdreq = 0;
`ifdef SCFIFO_S_ERR_FLAGS_EN
      chk("underflow_set", a_unf, 1);
`else
      chk("underflow_tied", a_unf, 0);
`endif

      // Fill to capacity, then one rejected push
      for (int i = 0; i < 32; i++) begin
         a_wrreq = 1; a_data = i;
         @(negedge clock);
         chk($sformatf("fill%0d_usedw", i), a_usedw, i + 1);
         chk($sformatf("fill%0d_af", i), a_af, (i + 1) >= 28);
         chk($sformatf("fill%0d_full", i), a_full, (i + 1) == 32);
      end
      a_data = 32'hDEAD;
      @(negedge clock);
      a_wrreq = 0;
      chk("ovf_usedw", a_usedw, 32);
      chk("ovf_full", a_full, 1);
`ifdef SCFIFO_S_ERR_FLAGS_EN
      chk("overflow_set", a_ovf, 1);
`else
      chk("overflow_tied", a_ovf, 0);
`endif

      // Drain in order
      begin
         int n, cyc;
         n = 0; cyc = 0;
         while (n < 32 && cyc < 200) begin
            if (!a_empty) begin
               chk($sformatf("drain%0d_q", n), a_q, n);
               a_rdreq = 1; n++;
            end else a_rdreq = 0;
            @(negedge clock); cyc++;
         end
         a_rdreq = 0;
         chk("drain_count", n, 32);
         chk("drain_usedw", a_usedw, 0);
         chk("drain_empty", a_empty, 1);
      end

      // Streaming: prime 4 words, then push+pop every cycle
      for (int i = 0; i < 4; i++) begin
         a_wrreq = 1; a_data = $urandom; mq.push_back(a_data);
         @(negedge clock);
      end
      a_wrreq = 0;
      repeat (4) @(negedge clock);
      for (int i = 0; i < 1000; i++) begin
         chk("stream_bubble", a_empty, 0);
         chk("stream_q", a_q, mq[0]);
         chk("stream_usedw", a_usedw, 4);
         a_wrreq = 1; a_rdreq = 1; a_data = $urandom;
         @(negedge clock);
         void'(mq.pop_front());
         mq.push_back(a_data);
      end
      a_wrreq = 0; a_rdreq = 0;

      // Reset mid-operation with 4 queued, then 13 more for 17 total
      for (int i = 0; i < 13; i++) begin
         a_wrreq = 1; a_data = i;
         @(negedge clock);
      end
      a_wrreq = 0;
      chk("pre_rst_usedw", a_usedw, 17);
      #3 aclr_n = 1'b0;
      #1;
      chk("arst_empty", a_empty, 1);
      chk("arst_usedw", a_usedw, 0);
      chk("arst_q", a_q, 0);
      chk("arst_full", a_full, 0);
      chk("arst_ae", a_ae, 1);
      chk("arst_af", a_af, 0);
      chk("arst_ovf", a_ovf, 0);
      chk("arst_unf", a_unf, 0);
      @(negedge clock);
      aclr_n = 1'b1;
      a_wrreq = 1; a_data = 32'h1;
      @(negedge clock);
      a_wrreq = 0;
      repeat (2) @(negedge clock);
      chk("post_rst_empty", a_empty, 0);
      chk("post_rst_q", a_q, 32'h1);
      chk("post_rst_usedw", a_usedw, 1);

      // Deep instance: random push/pop against a queue model
      begin
         int cnt;
         logic pa, pp;
         cnt = 0;
         for (int i = 0; i < 20000; i++) begin
            chk("deep_usedw", b_usedw, cnt);
            chk("deep_full", b_full, cnt == 1000);
            chk("deep_af", b_af, cnt >= 28);
            chk("deep_ae", b_ae, cnt < 2);
            if (!b_empty) begin
               chk("deep_head_exists", bq.size() > 0, 1'b1);
               if (bq.size() > 0) chk("deep_q", b_q, bq[0]);
            end
            b_wrreq = $urandom_range(0, 1);
            b_rdreq = $urandom_range(0, 1);
            b_data  = $urandom;
            pa = b_wrreq && (cnt != 1000);
            pp = b_rdreq && !b_empty;
            @(negedge clock);
            if (pp && bq.size() > 0) begin void'(bq.pop_front()); cnt--; end
            if (pa) begin bq.push_back(b_data); cnt++; end
         end
         b_wrreq = 0; b_rdreq = 0;
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
